// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared constants, FSM states and entry layout for the store buffer
package store_buffer_pkg;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam int   SB_DEPTH  = 4;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_WRITE = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_store_fmt.sv
// rtl/store_buffer_store_fmt.sv - combinational sw/sb encoder into data-memory byte-lane format
module store_fmt
  import store_buffer_pkg::*;
(
  input  logic        size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [3:0]  we_o,
  output logic [31:0] din_o
);

  // Memory lane 3 holds the lowest address, hence the byte reversal for words.
  always_comb begin
    we_o  = 4'b1111;
    din_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
    if (size_i == SIZE_BYTE) begin
      din_o = {4{data_i[7:0]}};
      unique case (offset_i)
        2'd0:    we_o = 4'b1000;
        2'd1:    we_o = 4'b0100;
        2'd2:    we_o = 4'b0010;
        default: we_o = 4'b0001;
      endcase
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO with req/ack drain to data memory and load-hazard detection
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic        st_valid_i,
  input  logic        st_size_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  output logic        st_ready_o,
  output logic        st_misalign_o,
  input  logic        ld_chk_i,
  input  logic [31:0] ld_addr_i,
  output logic        ld_hazard_o,
  output logic        dm_req_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_we_o,
  output logic [31:0] dm_din_o,
  input  logic        dm_ack_i,
  output logic        empty_o
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  sb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  sb_state_e     state_q;
  logic [31:0]   dm_addr_q, dm_din_q;
  logic [3:0]    dm_we_q;

  logic        push, pop, hazard;
  logic [3:0]  fmt_we;
  logic [31:0] fmt_din;
  sb_entry_t   push_entry;
  logic        ld_offset_unused;

  assign ld_offset_unused = &{1'b0, ld_addr_i[1:0]};

  store_fmt u_fmt (
    .size_i   (st_size_i),
    .offset_i (st_addr_i[1:0]),
    .data_i   (st_data_i),
    .we_o     (fmt_we),
    .din_o    (fmt_din)
  );

  assign st_misalign_o = st_valid_i & (st_size_i == SIZE_WORD) & (st_addr_i[1:0] != 2'b00);
  assign st_ready_o    = cpu_rst_n & (count_q < DEPTH_C);
  assign push          = st_valid_i & st_ready_o & ~st_misalign_o;
  assign pop           = (state_q == SB_WRITE) & dm_ack_i;
  assign push_entry    = '{addr: st_addr_i[31:2], we: fmt_we, din: fmt_din};

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // The head stays visible to the hazard check while it is being written.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count_q) && (mem_q[rd_ptr_q + PW'(i)].addr == ld_addr_i[31:2]))
        hazard = 1'b1;
    end
  end

  assign ld_hazard_o = ld_chk_i & hazard;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= SB_IDLE;
      dm_addr_q <= '0;
      dm_we_q   <= '0;
      dm_din_q  <= '0;
    end else begin
      unique case (state_q)
        SB_IDLE: begin
          if (count_q != '0) begin
            state_q   <= SB_WRITE;
            dm_addr_q <= {mem_q[rd_ptr_q].addr, 2'b00};
            dm_we_q   <= mem_q[rd_ptr_q].we;
            dm_din_q  <= mem_q[rd_ptr_q].din;
          end
        end
        default: begin
          if (dm_ack_i) state_q <= SB_IDLE;
        end
      endcase
    end
  end

  assign dm_req_o  = (state_q == SB_WRITE);
  assign dm_addr_o = dm_addr_q;
  assign dm_we_o   = dm_we_q;
  assign dm_din_o  = dm_din_q;
  assign empty_o   = (count_q == '0) & (state_q == SB_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer against a queue-based model
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic        st_valid_i, st_size_i;
  logic [31:0] st_addr_i, st_data_i;
  logic        st_ready_o, st_misalign_o;
  logic        ld_chk_i;
  logic [31:0] ld_addr_i;
  logic        ld_hazard_o;
  logic        dm_req_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_we_o;
  logic [31:0] dm_din_o;
  logic        dm_ack_i;
  logic        empty_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
  } ent_t;

  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst_n     (cpu_rst_n),
    .st_valid_i    (st_valid_i),
    .st_size_i     (st_size_i),
    .st_addr_i     (st_addr_i),
    .st_data_i     (st_data_i),
    .st_ready_o    (st_ready_o),
    .st_misalign_o (st_misalign_o),
    .ld_chk_i      (ld_chk_i),
    .ld_addr_i     (ld_addr_i),
    .ld_hazard_o   (ld_hazard_o),
    .dm_req_o      (dm_req_o),
    .dm_addr_o     (dm_addr_o),
    .dm_we_o       (dm_we_o),
    .dm_din_o      (dm_din_o),
    .dm_ack_i      (dm_ack_i),
    .empty_o       (empty_o)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic ent_t enc(input bit sz, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    e.addr = {a[31:2], 2'b00};
    if (sz) begin
      e.we  = 4'hF;
      e.din = {d[7:0], d[15:8], d[23:16], d[31:24]};
    end else begin
      e.we  = 4'b1000 >> a[1:0];
      e.din = {4{d[7:0]}};
    end
    return e;
  endfunction

  function automatic bit model_hazard(input logic [31:0] la);
    foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_store(input bit sz, input logic [31:0] a, input logic [31:0] d);
    bit exp_mis, exp_rdy;
    st_valid_i = 1'b1; st_size_i = sz; st_addr_i = a; st_data_i = d;
    #1;
    exp_mis = sz && (a[1:0] != 2'b00);
    exp_rdy = (q.size() < DEPTH);
    checks++;
    if (st_misalign_o !== exp_mis) begin
      errors++; $display("FAIL store_misalign addr=%h got=%b want=%b", a, st_misalign_o, exp_mis);
    end
    checks++;
    if (st_ready_o !== exp_rdy) begin
      errors++; $display("FAIL store_ready addr=%h got=%b want=%b", a, st_ready_o, exp_rdy);
    end
    @(posedge cpu_clk);
    if (exp_rdy && !exp_mis) q.push_back(enc(sz, a, d));
    #1;
    st_valid_i = 1'b0;
  endtask

  task automatic drain_one();
    int n = 0;
    ent_t e;
    while (!dm_req_o && n < 20) begin tick(); n++; end
    checks++;
    if (!dm_req_o || q.size() == 0) begin
      errors++; $display("FAIL drain_req got=%b want=1 pending=%0d", dm_req_o, q.size());
      return;
    end
    e = q[0];
    checks++;
    if (dm_addr_o !== e.addr || dm_we_o !== e.we || dm_din_o !== e.din) begin
      errors++;
      $display("FAIL drain_data got=%h/%b/%h want=%h/%b/%h", dm_addr_o, dm_we_o, dm_din_o, e.addr, e.we, e.din);
    end
    dm_ack_i = 1'b1;
    @(posedge cpu_clk);
    void'(q.pop_front());
    #1;
    dm_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0; ld_chk_i = 1'b1; ld_addr_i = 32'h0;
    repeat (2) @(posedge cpu_clk);
    #1;
    checks++; if (dm_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", dm_req_o); end
    checks++; if (dm_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h want=0", dm_addr_o); end
    checks++; if (dm_we_o !== 4'h0) begin errors++; $display("FAIL rst_we got=%b want=0", dm_we_o); end
    checks++; if (dm_din_o !== 32'h0) begin errors++; $display("FAIL rst_din got=%h want=0", dm_din_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b want=1", empty_o); end
    checks++; if (st_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", st_ready_o); end
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL rst_hazard got=%b want=0", ld_hazard_o); end
    cpu_rst_n = 1'b1;
    #1;
    checks++; if (st_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b want=1", st_ready_o); end
    ld_chk_i = 1'b0;
    tick();
  endtask

  task automatic test_word();
    do_store(1'b1, 32'h10, 32'h11223344);
    checks++; if (dm_req_o !== 1'b0) begin errors++; $display("FAIL word_req_early got=%b want=0", dm_req_o); end
    tick();
    checks++; if (dm_req_o !== 1'b1) begin errors++; $display("FAIL word_req_latency got=%b want=1", dm_req_o); end
    checks++;
    if (dm_addr_o !== 32'h10 || dm_we_o !== 4'hF || dm_din_o !== 32'h44332211) begin
      errors++; $display("FAIL word_fmt got=%h/%b/%h want=00000010/1111/44332211", dm_addr_o, dm_we_o, dm_din_o);
    end
    drain_one();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL word_empty got=%b want=1", empty_o); end
    checks++; if (dm_req_o !== 1'b0) begin errors++; $display("FAIL word_req_after got=%b want=0", dm_req_o); end
  endtask

  task automatic test_bytes();
    do_store(1'b0, 32'h13, 32'h000000AB);
    do_store(1'b0, 32'h11, 32'h000000AB);
    while (!dm_req_o && q.size() > 0) tick();
    checks++;
    if (dm_we_o !== 4'b0001 || dm_din_o !== 32'hABABABAB) begin
      errors++; $display("FAIL byte0_fmt got=%b/%h want=0001/abababab", dm_we_o, dm_din_o);
    end
    drain_one();
    while (!dm_req_o && q.size() > 0) tick();
    checks++;
    if (dm_we_o !== 4'b0100 || dm_din_o !== 32'hABABABAB || dm_addr_o !== 32'h10) begin
      errors++; $display("FAIL byte1_fmt got=%h/%b/%h want=00000010/0100/abababab", dm_addr_o, dm_we_o, dm_din_o);
    end
    drain_one();
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) do_store(1'b1, 32'h200 + 32'(i * 4), $urandom);
    checks++; if (q.size() != DEPTH) begin errors++; $display("FAIL full_model_count got=%0d want=%0d", q.size(), DEPTH); end
    checks++; if (st_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", st_ready_o); end
    drain_one();
    checks++; if (st_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got=%b want=1", st_ready_o); end
    repeat (3) drain_one();
    tick();
    checks++; if (empty_o !== 1'b1 || dm_req_o !== 1'b0) begin
      errors++; $display("FAIL full_drained got=%b/%b want=1/0", empty_o, dm_req_o);
    end
  endtask

  task automatic test_hazard();
    do_store(1'b1, 32'h20, $urandom);
    ld_chk_i = 1'b1; ld_addr_i = 32'h22; #1;
    checks++; if (ld_hazard_o !== 1'b1) begin errors++; $display("FAIL hazard_hit got=%b want=1", ld_hazard_o); end
    ld_addr_i = 32'h24; #1;
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL hazard_miss got=%b want=0", ld_hazard_o); end
    ld_addr_i = 32'h22; ld_chk_i = 1'b0; #1;
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL hazard_nochk got=%b want=0", ld_hazard_o); end
    drain_one();
    ld_chk_i = 1'b1; #1;
    checks++; if (ld_hazard_o !== 1'b0) begin errors++; $display("FAIL hazard_after_pop got=%b want=0", ld_hazard_o); end
    ld_chk_i = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    st_valid_i = 1'b0; st_size_i = 1'b1; st_addr_i = 32'h2; #1;
    checks++; if (st_misalign_o !== 1'b0) begin errors++; $display("FAIL mis_novalid got=%b want=0", st_misalign_o); end
    do_store(1'b1, 32'h2, $urandom);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dm_req_o !== 1'b0 || empty_o !== 1'b1) begin
        errors++; $display("FAIL mis_dropped cyc=%0d got=%b/%b want=0/1", i, dm_req_o, empty_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) do_store(1'b1, ($urandom & 32'hFFFF_FFFC), $urandom);
    checks++; if (dm_req_o !== 1'b1) begin errors++; $display("FAIL rmid_req_before got=%b want=1", dm_req_o); end
    #2;
    cpu_rst_n = 1'b0;
    #1;
    checks++; if (dm_req_o !== 1'b0) begin errors++; $display("FAIL rmid_req_async got=%b want=0", dm_req_o); end
    q.delete();
    #2;
    cpu_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dm_req_o !== 1'b0 || empty_o !== 1'b1) begin
        errors++; $display("FAIL rmid_idle cyc=%0d got=%b/%b want=0/1", i, dm_req_o, empty_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit v, sz, exp_mis, exp_rdy, exp_haz;
    logic [31:0] a, d;
    int n;
    for (int c = 0; c < 400; c++) begin
      v  = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      d  = $urandom;
      st_valid_i = v; st_size_i = sz; st_addr_i = a; st_data_i = d;
      ld_chk_i  = 1'($urandom_range(0, 1));
      ld_addr_i = 32'h100 + 32'($urandom_range(0, 31));
      dm_ack_i  = ($urandom_range(0, 2) == 0);
      #1;
      exp_mis = v && sz && (a[1:0] != 2'b00);
      exp_rdy = (q.size() < DEPTH);
      exp_haz = ld_chk_i && model_hazard(ld_addr_i);
      checks++;
      if (st_misalign_o !== exp_mis || st_ready_o !== exp_rdy || ld_hazard_o !== exp_haz) begin
        errors++;
        $display("FAIL rand_comb cyc=%0d got=%b%b%b want=%b%b%b", c, st_misalign_o, st_ready_o, ld_hazard_o, exp_mis, exp_rdy, exp_haz);
      end
      checks++;
      if (empty_o !== (q.size() == 0)) begin
        errors++; $display("FAIL rand_empty cyc=%0d got=%b want=%b", c, empty_o, q.size() == 0);
      end
      if (dm_req_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_req_empty cyc=%0d got=1 want=0", c);
        end else if (dm_addr_o !== q[0].addr || dm_we_o !== q[0].we || dm_din_o !== q[0].din) begin
          errors++;
          $display("FAIL rand_drain cyc=%0d got=%h/%b/%h want=%h/%b/%h", c, dm_addr_o, dm_we_o, dm_din_o, q[0].addr, q[0].we, q[0].din);
        end
      end
      @(posedge cpu_clk);
      if (dm_req_o && dm_ack_i && q.size() > 0) void'(q.pop_front());
      if (v && exp_rdy && !exp_mis) q.push_back(enc(sz, a, d));
      #1;
    end
    st_valid_i = 1'b0; ld_chk_i = 1'b0; dm_ack_i = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 8) begin drain_one(); n++; end
    tick();
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rand_final_empty got=%b want=1", empty_o); end
  endtask

  initial begin
    st_valid_i = 1'b0; st_size_i = 1'b0; st_addr_i = '0; st_data_i = '0;
    ld_chk_i = 1'b0; ld_addr_i = '0; dm_ack_i = 1'b0; cpu_rst_n = 1'b0;
    test_reset();
    test_word();
    test_bytes();
    test_full();
    test_hazard();
    test_misaligned();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
